// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave endpoint: oversamples scl/mosi/ss with clk,
// deserializes mosi words and serializes a host-loaded word on miso.
module spi_slave_if #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              frame_err
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] scl_q, mosi_q, ss_q;
  logic                   scl_d, ss_d;
  logic [SYNC_STAGES:0]   warm;
  logic                   live, scl_s, ss_s, mosi_s;
  logic                   scl_rise, scl_fall, ss_rise, ss_fall;

  state_t            state, state_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic [DATA_W-1:0] tx_buf, tx_buf_n;
  logic [DATA_W-1:0] rx_data_n;
  logic              skip, skip_n;
  logic              miso_n, rx_valid_n, tx_ready_n, frame_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q  <= '0;
      mosi_q <= '0;
      ss_q   <= '1;
      scl_d  <= 1'b0;
      ss_d   <= 1'b1;
      warm   <= '0;
    end else begin
      scl_q  <= {scl_q[SYNC_STAGES-2:0], scl};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
      scl_d  <= scl_q[SYNC_STAGES-1];
      ss_d   <= ss_q[SYNC_STAGES-1];
      warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are trusted only once the reset values have flushed out
  // of the chain, so a frame already in flight at reset is ignored.
  assign live     = warm[SYNC_STAGES];
  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign scl_rise = live & scl_s & ~scl_d;
  assign scl_fall = live & ~scl_s & scl_d;
  assign ss_rise  = live & ss_s & ~ss_d;
  assign ss_fall  = live & ~ss_s & ss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_buf    <= '0;
      rx_data   <= '0;
      skip      <= 1'b0;
      miso      <= 1'b0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_shift  <= rx_shift_n;
      tx_shift  <= tx_shift_n;
      tx_buf    <= tx_buf_n;
      rx_data   <= rx_data_n;
      skip      <= skip_n;
      miso      <= miso_n;
      rx_valid  <= rx_valid_n;
      tx_ready  <= tx_ready_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    rx_shift_n  = rx_shift;
    tx_shift_n  = tx_shift;
    tx_buf_n    = tx_buf;
    rx_data_n   = rx_data;
    skip_n      = skip;
    miso_n      = miso;
    rx_valid_n  = 1'b0;
    tx_ready_n  = tx_ready;
    frame_err_n = 1'b0;
    unique case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (ss_fall) begin
          state_n    = ACTIVE;
          bit_cnt_n  = '0;
          tx_shift_n = tx_buf;
          tx_ready_n = 1'b1;
          miso_n     = tx_buf[DATA_W-1];
          skip_n     = 1'b0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_n     = IDLE;
          miso_n      = 1'b0;
          bit_cnt_n   = '0;
          frame_err_n = (bit_cnt != '0);
        end else if (scl_rise) begin
          rx_shift_n = {rx_shift[DATA_W-2:0], mosi_s};
          if (bit_cnt == CW'(DATA_W-1)) begin
            rx_data_n  = rx_shift_n;
            rx_valid_n = 1'b1;
            bit_cnt_n  = '0;
            tx_shift_n = tx_buf;
            tx_ready_n = 1'b1;
            miso_n     = tx_buf[DATA_W-1];
            skip_n     = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else if (scl_fall) begin
          if (skip) begin
            skip_n = 1'b0;
          end else begin
            tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
            miso_n     = tx_shift[DATA_W-2];
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A load always lands after any reload so the reload sees the old word.
    if (tx_load) begin
      tx_buf_n   = tx_data;
      tx_ready_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a behavioural SPI master plus a word-level
// model of what the slave should receive and return.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b0;
  logic       mosi = 1'b0;
  logic       ss = 1'b1;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic       frame_err;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mw [4];
  logic [7:0] mr [4];
  logic [7:0] rxq [$];
  int         ferr_cnt = 0;
  logic [7:0] model_buf = 8'h00;
  logic [7:0] model_rx = 8'h00;

  spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .mosi(mosi), .ss(ss),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (frame_err) ferr_cnt++;
  end

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    model_buf = v;
  endtask

  task automatic spi_frame(input int n);
    ss = 1'b0;
    repeat (10) @(negedge clk);
    for (int w = 0; w < n; w++) begin
      for (int b = 7; b >= 0; b--) begin
        mosi = mw[w][b];
        repeat (8) @(negedge clk);
        mr[w][b] = miso;
        scl = 1'b1;
        repeat (8) @(negedge clk);
        scl = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    ss = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic spi_partial(input int nbits, input bit do_rst);
    ss = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (8) @(negedge clk);
      scl = 1'b1;
      repeat (8) @(negedge clk);
      scl = 1'b0;
    end
    if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mosi = 1'($urandom_range(0, 1));
        repeat (8) @(negedge clk);
        scl = 1'b1;
        repeat (8) @(negedge clk);
        scl = 1'b0;
      end
      if (miso !== 1'b0) begin
        mismatched++;
        $display("FAIL ignored_frame_miso got=%b exp=0", miso);
      end
      compared++;
    end
    repeat (8) @(negedge clk);
    ss = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      scl = ~scl;
      mosi = ~mosi;
      if (miso !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_miso got=%b exp=0", miso);
      end
      compared++;
      if (rx_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_rx_valid got=%b exp=0", rx_valid);
      end
      compared++;
      if (tx_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_tx_ready got=%b exp=1", tx_ready);
      end
      compared++;
      if (rx_data !== 8'h00) begin
        mismatched++;
        $display("FAIL reset_rx_data got=%h exp=00", rx_data);
      end
      compared++;
    end
    scl = 1'b0;
    mosi = 1'b0;
    ss = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single;
    rxq.delete();
    load(8'h3C);
    if (tx_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL single_tx_ready_after_load got=%b exp=0", tx_ready);
    end
    compared++;
    mw[0] = 8'hA5;
    spi_frame(1);
    model_rx = 8'hA5;
    if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin
      mismatched++;
      $display("FAIL single_rx count=%0d first=%h exp=1 A5",
               rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
    compared++;
    if (mr[0] !== model_buf) begin
      mismatched++;
      $display("FAIL single_miso got=%h exp=%h", mr[0], model_buf);
    end
    compared++;
    if (tx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL single_tx_ready got=%b exp=1", tx_ready);
    end
    compared++;
  endtask

  task automatic test_back_to_back;
    rxq.delete();
    load(8'h81);
    mw[0] = 8'h12;
    mw[1] = 8'h34;
    spi_frame(2);
    model_rx = 8'h34;
    for (int w = 0; w < 2; w++) begin
      if (rxq.size() <= w || rxq[w] !== mw[w]) begin
        mismatched++;
        $display("FAIL b2b_rx%0d count=%0d exp=%h", w, rxq.size(), mw[w]);
      end
      compared++;
      if (mr[w] !== model_buf) begin
        mismatched++;
        $display("FAIL b2b_miso%0d got=%h exp=%h", w, mr[w], model_buf);
      end
      compared++;
    end
    if (rxq.size() != 2) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d exp=2", rxq.size());
    end
    compared++;
  endtask

  task automatic test_abort;
    rxq.delete();
    ferr_cnt = 0;
    spi_partial(5, 1'b0);
    if (ferr_cnt != 1) begin
      mismatched++;
      $display("FAIL abort_frame_err got=%0d exp=1", ferr_cnt);
    end
    compared++;
    if (rxq.size() != 0) begin
      mismatched++;
      $display("FAIL abort_rx_valid got=%0d exp=0", rxq.size());
    end
    compared++;
    if (rx_data !== model_rx) begin
      mismatched++;
      $display("FAIL abort_rx_data got=%h exp=%h", rx_data, model_rx);
    end
    compared++;
    mw[0] = 8'h5A;
    spi_frame(1);
    model_rx = 8'h5A;
    if (rxq.size() != 1 || rxq[0] !== 8'h5A || ferr_cnt != 1) begin
      mismatched++;
      $display("FAIL abort_next_frame count=%0d ferr=%0d exp=1 1",
               rxq.size(), ferr_cnt);
    end
    compared++;
  endtask

  task automatic test_late_load;
    logic [7:0] first_buf;
    rxq.delete();
    load(8'h0F);
    first_buf = model_buf;
    mw[0] = 8'($urandom);
    mw[1] = 8'($urandom);
    fork
      spi_frame(2);
      begin
        repeat (60) @(negedge clk);
        load(8'hF0);
      end
    join
    model_rx = mw[1];
    if (mr[0] !== first_buf) begin
      mismatched++;
      $display("FAIL late_word0 got=%h exp=%h", mr[0], first_buf);
    end
    compared++;
    if (mr[1] !== model_buf) begin
      mismatched++;
      $display("FAIL late_word1 got=%h exp=%h", mr[1], model_buf);
    end
    compared++;
    if (rxq.size() != 2 || rxq[0] !== mw[0] || rxq[1] !== mw[1]) begin
      mismatched++;
      $display("FAIL late_rx count=%0d exp=2 words %h %h",
               rxq.size(), mw[0], mw[1]);
    end
    compared++;
  endtask

  task automatic test_reset_mid_frame;
    rxq.delete();
    ferr_cnt = 0;
    spi_partial(4, 1'b1);
    model_buf = 8'h00;
    model_rx = 8'h00;
    if (rx_data !== model_rx) begin
      mismatched++;
      $display("FAIL rstmid_rx_data got=%h exp=%h", rx_data, model_rx);
    end
    compared++;
    mw[0] = 8'hC3;
    spi_frame(1);
    if (rxq.size() != 1 || rx_data !== 8'hC3) begin
      mismatched++;
      $display("FAIL rstmid_rx count=%0d data=%h exp=1 C3",
               rxq.size(), rx_data);
    end
    compared++;
    if (ferr_cnt != 0) begin
      mismatched++;
      $display("FAIL rstmid_frame_err got=%0d exp=0", ferr_cnt);
    end
    compared++;
    if (mr[0] !== model_buf) begin
      mismatched++;
      $display("FAIL rstmid_miso got=%h exp=%h", mr[0], model_buf);
    end
    compared++;
  endtask

  task automatic test_random;
    int n;
    for (int f = 0; f < 4; f++) begin
      rxq.delete();
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      for (int w = 0; w < n; w++) mw[w] = 8'($urandom);
      spi_frame(n);
      for (int w = 0; w < n; w++) begin
        if (rxq.size() <= w || rxq[w] !== mw[w]) begin
          mismatched++;
          $display("FAIL rand_rx f%0d w%0d count=%0d exp=%h",
                   f, w, rxq.size(), mw[w]);
        end
        compared++;
        if (mr[w] !== model_buf) begin
          mismatched++;
          $display("FAIL rand_miso f%0d w%0d got=%h exp=%h",
                   f, w, mr[w], model_buf);
        end
        compared++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_abort;
    test_late_load;
    test_reset_mid_frame;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule
